noc_dispatch_ctrl: RTL and testbench
====================================

NOC_DISPATCH_CTRL -- requirements
Module: noc_dispatch_ctrl

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16: product data width.
REQ-002 SHALL have parameter LOG_N_ADD, default 6: log2 of adder count (N_ADD = 2**LOG_N_ADD).
REQ-003 SHALL have parameter LOG_CRED, default 2: log2 of per-adder credit depth (CRED_MAX = 2**LOG_CRED).
REQ-004 SHALL have port clk, input, 1: single clock.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1: packet valid from root of multiplier mux tree.
REQ-007 SHALL have port in_addr, input, LOG_N_ADD: destination adder index.
REQ-008 SHALL have port in_data, input, BIT_WIDTH: product value.
REQ-009 SHALL have port in_busy, output, 1: backpressure to root mux; high = packet not accepted.
REQ-010 SHALL have port out_data, output, BIT_WIDTH: data driven into demux tree.
REQ-011 SHALL have port out_addr, output, LOG_N_ADD: select driven into demux tree.
REQ-012 SHALL have port out_val, output, N_ADD: one-hot valid per adder.
REQ-013 SHALL have port credit_ret, input, N_ADD: one-cycle pulse per adder freeing one slot.
REQ-014 SHALL have port stall_cnt, output, 16: saturating count of head-blocked cycles.
REQ-015 SHALL have port cred_err, output, 1: sticky credit overflow flag.

Function
REQ-016 SHALL hold accepted packets in an in-order 2-entry FIFO; accept on in_valid && !in_busy.
REQ-017 SHALL drive in_busy = (FIFO count == 2), registered-state derived, no combinational path from in_valid.
REQ-018 SHALL keep per-adder credit counter, width LOG_CRED+1, range 0..CRED_MAX.
REQ-019 SHALL issue FIFO head when head valid and credit[head_addr] > 0: pop head, decrement that credit.
REQ-020 SHALL register outputs: issue decided in cycle C -> out_val[addr] high, out_data/out_addr valid in cycle C+1, one cycle only.
REQ-021 SHALL give latency 2 cycles from acceptance (edge ending cycle N) to out_val (cycle N+2) when FIFO empty and credit available; sustained throughput 1 packet/cycle.
REQ-022 SHALL allow push and pop in the same cycle; count unchanged.
REQ-023 SHALL never reorder: blocked head blocks all later packets (no bypass).
REQ-024 SHALL hold out_data/out_addr at last issued values and out_val = 0 when no issue.
REQ-025 SHALL, on credit_ret[k] with no same-cycle issue to k, increment credit[k]; on both same cycle, leave credit[k] unchanged.
REQ-026 SHALL, on credit_ret[k] with credit[k] == CRED_MAX and no same-cycle issue to k, saturate and set cred_err (cleared only by rst).
REQ-027 SHALL implement state FSM: EMPTY (count 0), READY (head issuable), BLOCKED (head present, credit 0); transitions evaluated every cycle from count and head credit.
REQ-028 SHALL increment stall_cnt each BLOCKED cycle, saturating at 0xFFFF.
REQ-029 SHALL ignore in_data/in_addr when in_valid low or in_busy high.

Reset
REQ-030 SHALL on rst: FIFO count 0, FSM EMPTY, all credits = CRED_MAX, out_val = 0, out_data = 0, out_addr = 0, in_busy = 0, stall_cnt = 0, cred_err = 0.
REQ-031 SHALL on rst mid-operation discard FIFO contents and pending issue; out_val 0 the cycle after rst asserted.
REQ-032 SHALL ignore credit_ret and in_valid while rst high.

Verification
REQ-033 SHALL cover: after rst, in_valid one cycle, addr=5, data=0x1234 -> out_val=0x20 in cycle N+2, out_addr=5, out_data=0x1234, credit[5]=3.
REQ-034 SHALL cover: 5 back-to-back packets to addr 7, no credit_ret -> 4 issued consecutive cycles, 5th held, FSM BLOCKED, stall_cnt increments, in_busy high once second packet queued behind it.
REQ-035 SHALL cover: from REQ-034 state, credit_ret[7] pulse -> 5th packet issued 2 cycles later, stall_cnt frozen, in_busy drops.
REQ-036 SHALL cover: issue to addr 3 and credit_ret[3] same cycle -> credit[3] unchanged; credit_ret[9] with credit[9]=4 -> cred_err=1, credit[9]=4.
REQ-037 SHALL cover: continuous in_valid alternating addr 0/63 with credits returned -> out_val every cycle, in order, in_busy never high.
REQ-038 SHALL cover: rst asserted with 2 packets queued -> next cycle out_val=0, in_busy=0, all credits 4, no queued packet ever issued.

Source files
------------

// File: rtl/noc_dispatch_ctrl_if.sv
// Bundle of the dispatch controller's packet, demux and status signals.
//
// Handshake: a packet on in_valid/in_addr/in_data is taken at the rising clk
// edge where in_valid is high and in_busy is low. in_busy depends only on
// registered state, so the source may look at it before raising in_valid.
// Data/addr are don't-care whenever that condition is false.
interface noc_dispatch_ctrl_if #(
    parameter int BIT_WIDTH = 16,
    parameter int LOG_N_ADD = 6,
    parameter int LOG_CRED  = 2
);
    localparam int N_ADD = 2 ** LOG_N_ADD;
    localparam int CW    = LOG_CRED + 1;

    logic                   in_valid;
    logic [LOG_N_ADD-1:0]   in_addr;
    logic [BIT_WIDTH-1:0]   in_data;
    logic                   in_busy;
    logic [BIT_WIDTH-1:0]   out_data;
    logic [LOG_N_ADD-1:0]   out_addr;
    logic [N_ADD-1:0]       out_val;
    logic [N_ADD-1:0]       credit_ret;
    logic [15:0]            stall_cnt;
    logic                   cred_err;
    // Debug visibility: FSM state and flattened per-adder credit counters.
    logic [1:0]             state_dbg;
    logic [N_ADD*CW-1:0]    credit_dbg;

    modport master (
        output in_valid, in_addr, in_data, credit_ret,
        input  in_busy, out_data, out_addr, out_val, stall_cnt, cred_err,
               state_dbg, credit_dbg
    );

    modport slave (
        input  in_valid, in_addr, in_data, credit_ret,
        output in_busy, out_data, out_addr, out_val, stall_cnt, cred_err,
               state_dbg, credit_dbg
    );
endinterface

// File: rtl/noc_dispatch_ctrl.sv
// Root dispatcher between the multiplier mux tree and the adder demux tree.
// Packets wait in a strictly in-order 2-entry FIFO; the head is issued only
// when its destination adder has a free credit slot. A blocked head stalls
// everything behind it.
module noc_dispatch_ctrl #(
    parameter int BIT_WIDTH = 16,
    parameter int LOG_N_ADD = 6,
    parameter int LOG_CRED  = 2
) (
    input logic              clk,
    input logic              rst,
    noc_dispatch_ctrl_if.slave bus
);
    localparam int N_ADD = 2 ** LOG_N_ADD;
    localparam int CW    = LOG_CRED + 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(2 ** LOG_CRED);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_READY   = 2'd1,
        S_BLOCKED = 2'd2
    } state_t;

    state_t                 state_q, state_n;
    logic [LOG_N_ADD-1:0]   fifo_addr_q [2];
    logic [LOG_N_ADD-1:0]   fifo_addr_n [2];
    logic [BIT_WIDTH-1:0]   fifo_data_q [2];
    logic [BIT_WIDTH-1:0]   fifo_data_n [2];
    logic                   wr_ptr_q, wr_ptr_n;
    logic                   rd_ptr_q, rd_ptr_n;
    logic [1:0]             cnt_q, cnt_n;
    logic [CW-1:0]          cred_q [N_ADD];
    logic [CW-1:0]          cred_n [N_ADD];
    logic                   cred_err_q, cred_err_n;
    logic [15:0]            stall_q;
    logic [N_ADD-1:0]       out_val_q;
    logic [BIT_WIDTH-1:0]   out_data_q;
    logic [LOG_N_ADD-1:0]   out_addr_q;
    logic                   push;
    logic                   issue;
    logic [LOG_N_ADD-1:0]   head_addr;
    logic [BIT_WIDTH-1:0]   head_data;

    // The state register always describes the current FIFO head, so READY
    // is exactly the "issue this cycle" condition.
    assign head_addr = fifo_addr_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];
    assign issue     = (state_q == S_READY);
    assign push      = bus.in_valid && (cnt_q != 2'd2);

    // Next FIFO contents, pointers, occupancy and credit counters.
    always_comb begin
        fifo_addr_n = fifo_addr_q;
        fifo_data_n = fifo_data_q;
        wr_ptr_n    = wr_ptr_q;
        rd_ptr_n    = rd_ptr_q;
        cnt_n       = cnt_q;
        cred_n      = cred_q;
        cred_err_n  = cred_err_q;
        if (push) begin
            fifo_addr_n[wr_ptr_q] = bus.in_addr;
            fifo_data_n[wr_ptr_q] = bus.in_data;
            wr_ptr_n              = ~wr_ptr_q;
        end
        if (issue) begin
            rd_ptr_n = ~rd_ptr_q;
        end
        case ({push, issue})
            2'b10:   cnt_n = cnt_q + 2'd1;
            2'b01:   cnt_n = cnt_q - 2'd1;
            default: cnt_n = cnt_q;
        endcase
        for (int k = 0; k < N_ADD; k++) begin
            // A return and an issue to the same adder cancel out.
            if (bus.credit_ret[k] && !(issue && head_addr == LOG_N_ADD'(k))) begin
                if (cred_q[k] == CRED_MAX) begin
                    cred_err_n = 1'b1;
                end else begin
                    cred_n[k] = cred_q[k] + CW'(1);
                end
            end else if (!bus.credit_ret[k] && issue && head_addr == LOG_N_ADD'(k)) begin
                cred_n[k] = cred_q[k] - CW'(1);
            end
        end
    end

    // Classify next cycle's head from next-cycle occupancy and credits.
    always_comb begin
        state_n = S_EMPTY;
        if (cnt_n != 2'd0) begin
            if (cred_n[fifo_addr_n[rd_ptr_n]] != '0) begin
                state_n = S_READY;
            end else begin
                state_n = S_BLOCKED;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_n;
        end
    end

    // FIFO, credit and error registers; reset discards queued packets.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            cred_err_q <= 1'b0;
            for (int k = 0; k < N_ADD; k++) begin
                cred_q[k] <= CRED_MAX;
            end
        end else begin
            fifo_addr_q <= fifo_addr_n;
            fifo_data_q <= fifo_data_n;
            wr_ptr_q    <= wr_ptr_n;
            rd_ptr_q    <= rd_ptr_n;
            cnt_q       <= cnt_n;
            cred_err_q  <= cred_err_n;
            cred_q      <= cred_n;
        end
    end

    // Registered demux outputs; data/addr hold their last issued values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_val_q  <= '0;
            out_data_q <= '0;
            out_addr_q <= '0;
        end else begin
            out_val_q <= issue ? (N_ADD'(1) << head_addr) : '0;
            if (issue) begin
                out_data_q <= head_data;
                out_addr_q <= head_addr;
            end
        end
    end

    // Saturating count of cycles the head spends blocked on credit.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 16'd0;
        end else if (state_q == S_BLOCKED && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.in_busy   = (cnt_q == 2'd2);
    assign bus.out_val   = out_val_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.stall_cnt = stall_q;
    assign bus.cred_err  = cred_err_q;
    assign bus.state_dbg = state_q;

    for (genvar g = 0; g < N_ADD; g++) begin : g_cred_dbg
        assign bus.credit_dbg[g*CW +: CW] = cred_q[g];
    end
endmodule

// File: tb/tb_noc_dispatch_ctrl.sv
// Directed bench for noc_dispatch_ctrl: latency, credit blocking/release,
// credit corner cases, streaming throughput and mid-flight reset.
module tb_noc_dispatch_ctrl;
    localparam int BW = 16;
    localparam int LA = 6;
    localparam int LC = 2;
    localparam int CW = LC + 1;
    localparam int W  = LA + BW;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_issued = 0;
    logic [W-1:0] exp_q[$];

    noc_dispatch_ctrl_if #(.BIT_WIDTH(BW), .LOG_N_ADD(LA), .LOG_CRED(LC)) bus ();

    noc_dispatch_ctrl #(.BIT_WIDTH(BW), .LOG_N_ADD(LA), .LOG_CRED(LC)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] cred_of(input int k);
        return bus.credit_dbg[k*CW +: CW];
    endfunction

    // Advance one cycle, then scoreboard any issued packet.
    task automatic step();
        logic [W-1:0] e;
        logic [63:0]  one;
        @(posedge clk);
        #1;
        if (bus.out_val != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 64'(bus.out_val), 64'd0);
            end else begin
                e   = exp_q.pop_front();
                one = 64'd1;
                check("sb_addr", 64'(bus.out_addr), 64'(e[W-1:BW]));
                check("sb_data", 64'(bus.out_data), 64'(e[BW-1:0]));
                check("sb_onehot", 64'(bus.out_val), one << e[W-1:BW]);
                n_issued++;
            end
        end
    endtask

    task automatic drive_pkt(input logic [LA-1:0] a, input logic [BW-1:0] d, input bit expect_issue);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
        if (expect_issue) exp_q.push_back({a, d});
    endtask

    initial begin
        int base;
        logic [LA-1:0] a;
        logic [LA-1:0] prev_a;
        logic [63:0] one;
        one = 64'd1;
        prev_a = '0;
        rst = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_addr    = '0;
        bus.in_data    = '0;
        bus.credit_ret = '0;
        step();
        step();
        rst = 1'b0;

        // Reset values
        check("rst_out_val", 64'(bus.out_val), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_addr", 64'(bus.out_addr), 64'd0);
        check("rst_busy", 64'(bus.in_busy), 64'd0);
        check("rst_stall", 64'(bus.stall_cnt), 64'd0);
        check("rst_cred_err", 64'(bus.cred_err), 64'd0);
        check("rst_state", 64'(bus.state_dbg), 64'd0);
        for (int k = 0; k < 64; k++) check("rst_credit", 64'(cred_of(k)), 64'd4);

        // Single packet latency
        drive_pkt(6'd5, 16'h1234, 1'b1);
        step();
        bus.in_valid = 1'b0;
        check("lat_n1_val", 64'(bus.out_val), 64'd0);
        check("lat_n1_state", 64'(bus.state_dbg), 64'd1);
        step();
        check("lat_n2_val", 64'(bus.out_val), 64'h20);
        check("lat_n2_addr", 64'(bus.out_addr), 64'd5);
        check("lat_n2_data", 64'(bus.out_data), 64'h1234);
        check("lat_cred5", 64'(cred_of(5)), 64'd3);
        check("lat_state_empty", 64'(bus.state_dbg), 64'd0);
        step();
        check("hold_val", 64'(bus.out_val), 64'd0);
        check("hold_data", 64'(bus.out_data), 64'h1234);
        check("hold_addr", 64'(bus.out_addr), 64'd5);
        bus.credit_ret = 64'd1 << 5;
        step();
        bus.credit_ret = '0;
        check("ret_cred5", 64'(cred_of(5)), 64'd4);
        check("ret_no_err", 64'(bus.cred_err), 64'd0);

        // Credit exhaustion on adder 7, sixth packet to adder 8 queues behind
        base = n_issued;
        for (int i = 0; i < 6; i++) begin
            drive_pkt((i == 5) ? 6'd8 : 6'd7, 16'h0700 + 16'(i), 1'b1);
            step();
            check("fill_busy", 64'(bus.in_busy), (i == 5) ? 64'd1 : 64'd0);
        end
        bus.in_valid = 1'b0;
        check("blk_issued4", 64'(n_issued - base), 64'd4);
        check("blk_state", 64'(bus.state_dbg), 64'd2);
        check("blk_stall1", 64'(bus.stall_cnt), 64'd1);
        check("blk_cred7", 64'(cred_of(7)), 64'd0);
        check("blk_val", 64'(bus.out_val), 64'd0);
        step(); step(); step();
        check("blk_stall4", 64'(bus.stall_cnt), 64'd4);
        check("blk_val_still0", 64'(bus.out_val), 64'd0);
        check("blk_busy_hold", 64'(bus.in_busy), 64'd1);

        // Credit release frees the head
        bus.credit_ret = 64'd1 << 7;
        step();
        bus.credit_ret = '0;
        check("rel_cred7", 64'(cred_of(7)), 64'd1);
        check("rel_state", 64'(bus.state_dbg), 64'd1);
        check("rel_stall5", 64'(bus.stall_cnt), 64'd5);
        step();
        check("rel_val7", 64'(bus.out_val), 64'h80);
        check("rel_data", 64'(bus.out_data), 64'h0704);
        check("rel_busy_drop", 64'(bus.in_busy), 64'd0);
        check("rel_stall_frozen", 64'(bus.stall_cnt), 64'd5);
        step();
        check("rel_val8", 64'(bus.out_val), one << 8);
        check("rel_data8", 64'(bus.out_data), 64'h0705);
        check("rel_state_empty", 64'(bus.state_dbg), 64'd0);
        step();
        check("rel_stall_final", 64'(bus.stall_cnt), 64'd5);

        // Same-cycle issue and return; overflow return
        drive_pkt(6'd3, 16'h0333, 1'b1);
        step();
        bus.in_valid = 1'b0;
        bus.credit_ret = 64'd1 << 3;
        check("co_state", 64'(bus.state_dbg), 64'd1);
        step();
        bus.credit_ret = 64'd1 << 9;
        check("co_cred3", 64'(cred_of(3)), 64'd4);
        check("co_val3", 64'(bus.out_val), 64'h8);
        check("co_err_clear", 64'(bus.cred_err), 64'd0);
        step();
        bus.credit_ret = '0;
        check("ovf_err", 64'(bus.cred_err), 64'd1);
        check("ovf_cred9", 64'(cred_of(9)), 64'd4);
        step();
        check("ovf_err_sticky", 64'(bus.cred_err), 64'd1);

        // Streaming alternating adders with credits returned
        for (int i = 0; i < 16; i++) begin
            a = (i % 2 == 1) ? 6'd63 : 6'd0;
            drive_pkt(a, 16'($urandom_range(0, 16'hFFFF)), 1'b1);
            bus.credit_ret = bus.out_val;
            step();
            check("strm_busy", 64'(bus.in_busy), 64'd0);
            if (i >= 1) check("strm_val", 64'(bus.out_val), one << prev_a);
            prev_a = a;
        end
        bus.in_valid = 1'b0;
        bus.credit_ret = bus.out_val;
        step();
        check("strm_last_val", 64'(bus.out_val), one << 63);
        bus.credit_ret = bus.out_val;
        step();
        bus.credit_ret = '0;
        check("strm_drained", 64'(exp_q.size()), 64'd0);

        // Reset with two packets queued behind a blocked head
        drive_pkt(6'd7, 16'h0AA0, 1'b0);
        step();
        drive_pkt(6'd7, 16'h0AA1, 1'b0);
        step();
        bus.in_valid = 1'b0;
        check("q2_busy", 64'(bus.in_busy), 64'd1);
        check("q2_state", 64'(bus.state_dbg), 64'd2);
        rst = 1'b1;
        drive_pkt(6'd7, 16'h0BAD, 1'b0);
        bus.credit_ret = '1;
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.credit_ret = '0;
        check("mrst_val", 64'(bus.out_val), 64'd0);
        check("mrst_busy", 64'(bus.in_busy), 64'd0);
        check("mrst_state", 64'(bus.state_dbg), 64'd0);
        check("mrst_stall", 64'(bus.stall_cnt), 64'd0);
        check("mrst_err", 64'(bus.cred_err), 64'd0);
        for (int k = 0; k < 64; k++) check("mrst_credit", 64'(cred_of(k)), 64'd4);
        base = n_issued;
        for (int i = 0; i < 5; i++) step();
        check("mrst_no_issue", 64'(n_issued - base), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
